// File: rtl/alu32_pkg.sv
// Shared ALU definitions: operation select codes, modulus FSM state encoding
// and the iteration-counter sizing helper used by the multi-cycle MOD engine.
package alu32_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_XOR = 3'b010,
        ALU_ADD = 3'b011,
        ALU_SUB = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SHL = 3'b110,
        ALU_MOD = 3'b111
    } alu_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mod_state_e;

    localparam int MOD_DEF_WIDTH = 32;

    // One spare bit so the counter can also represent WIDTH itself.
    function automatic int mod_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int MOD_CNT_W = mod_cnt_width(MOD_DEF_WIDTH);

endpackage

// File: rtl/alu32_mod_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module alu32_mod_step
    import alu32_pkg::*;
#(
    parameter int WIDTH = MOD_DEF_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   next_rem
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] dvs_ext;
    logic           rem_top_unused;

    // The partial remainder is always below the divisor, so its top bit is zero.
    assign rem_top_unused = rem[WIDTH];
    assign trial          = {rem[WIDTH-1:0], dvd_msb};
    assign dvs_ext        = {1'b0, dvs};

    always_comb begin
        // NOTE: assign a default first so every path drives next_rem and no latch is inferred.
        next_rem = trial;
        if (trial >= dvs_ext) begin
            next_rem = trial - dvs_ext;
        end
    end

endmodule

// File: rtl/alu32_mod_unit.sv
// Multi-cycle unsigned modulus engine (ALU op MOD): res = a mod b by restoring
// division, one bit per clock, behind a four-phase start/done handshake.
module alu32_mod_unit
    import alu32_pkg::*;
#(
    parameter int WIDTH = MOD_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] res
);

    localparam int                CNT_W    = mod_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mod_state_e       state_q;
    mod_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH:0]   next_rem;
    logic [WIDTH-1:0] res_q;

    alu32_mod_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_q),
        .dvd_msb  (dvd_q[WIDTH-1]),
        .dvs      (dvs_q),
        .next_rem (next_rem)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (b == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            res_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dvd_q <= a;
                        dvs_q <= b;
                        rem_q <= '0;
                        cnt_q <= '0;
                        // Division by zero short-circuits with the dividend as result.
                        if (b == '0) begin
                            res_q <= a;
                        end
                    end
                end
                CALC: begin
                    dvd_q <= dvd_q << 1;
                    rem_q <= next_rem;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        res_q <= next_rem[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign done = (state_q == DONE);
    assign busy = (state_q == CALC);
    assign res  = res_q;

endmodule

// File: tb/tb_alu32_mod_unit.sv
// Self-checking bench for alu32_mod_unit: directed and random operands checked
// against plain a % b arithmetic, plus handshake, latency and reset behaviour.
module tb_alu32_mod_unit;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 200;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             done;
    logic             busy;
    logic [WIDTH-1:0] res;

    int total;
    int bad;

    alu32_mod_unit #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .done  (done),
        .busy  (busy),
        .res   (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return (y == 0) ? x : x % y;
    endfunction

    // Posedges counted from raising start until done is observed: the accept
    // edge plus WIDTH steps, or just the accept edge for a zero divisor.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b);
        logic [WIDTH-1:0] exp_res;
        int               exp_lat;
        int               lat;
        bit               saw_busy;
        exp_res  = ref_mod(op_a, op_b);
        exp_lat  = (op_b == 0) ? 1 : WIDTH + 1;
        lat      = 0;
        saw_busy = 0;
        @(negedge clk);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        while (!done && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) saw_busy = 1;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, 64'(res), 64'(exp_res));
        check({tag, "_busy_seen"}, 64'(saw_busy), 64'(op_b != 0));
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, 64'(done), 64'd0);
        check({tag, "_res_hold"}, 64'(res), 64'(exp_res));
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int               lat;
        int               done_cycles;

        total = 0;
        bad   = 0;
        reset = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_done", 64'(done), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_res", 64'(res), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("a_lt_b", 32'd5, 32'd12);
        run_op("mod46_32", 32'd46, 32'd32);
        run_op("max_mod7", 32'hFFFF_FFFF, 32'd7);
        run_op("div_zero", 32'h0000_1234, 32'd0);
        run_op("a_eq_b", 32'd987654, 32'd987654);
        run_op("b_one", 32'hCAFE_F00D, 32'd1);
        run_op("a_zero", 32'd0, 32'd55);
        run_op("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i < 4) ? WIDTH'($urandom_range(1, 1000)) : $urandom;
            run_op($sformatf("rand%0d", i), ra, rb);
        end

        // Operands churn every CALC cycle and start drops mid-calculation.
        @(negedge clk);
        a     = 32'd12345678;
        b     = 32'd1000;
        start = 1'b1;
        @(posedge clk);
        #1;
        lat = 1;
        while (!done && lat < TIMEOUT) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            if (lat == 10) start = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check("churn_lat", 64'(lat), 64'(WIDTH + 1));
        check("churn_res", 64'(res), 64'(ref_mod(32'd12345678, 32'd1000)));
        done_cycles = 0;
        while (done && done_cycles < 4) begin
            done_cycles++;
            @(posedge clk);
            #1;
        end
        check("churn_done_pulse", 64'(done_cycles), 64'd1);
        check("churn_idle_busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        a     = 32'hDEAD_BEEF;
        b     = 32'd77;
        start = 1'b1;
        @(posedge clk);
        repeat (15) @(posedge clk);
        #2;
        check("abort_busy_pre", 64'(busy), 64'd1);
        reset = 1'b0;
        start = 1'b0;
        #1;
        check("abort_done", 64'(done), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_res", 64'(res), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op("post_abort", 32'd100, 32'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
